// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and response codes.
// The FSM is 3 bits wide so it can hold all six transaction phases.
package mem_if_pkg;
  localparam int STATE_WDTH = 3;
  localparam int RESP_OKAY  = 0;

  typedef enum logic [STATE_WDTH-1:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit after rr_ptr, with wrap-around.
// Zero latency; produces no grant when req is empty.
module rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int IDX_WDTH = 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_WDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  gnt_oh,
  output logic [IDX_WDTH-1:0] gnt_idx,
  output logic                gnt_any
);

  always_comb begin
    int k;
    k       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_any && req[k]) begin
        gnt_any    = 1'b1;
        gnt_oh[k]  = 1'b1;
        gnt_idx    = IDX_WDTH'(k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one AXI-lite-style memory port among NUM_REQ requesters, one transaction at a time.
// Accept at t0, address at t1, data/resp at t2, rsp_valid at t3 when memory is ready; any channel may stall.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WDTH-1:0]           rsp_rdata,
  output logic [RESP_WDTH-1:0]           rsp_resp,
  output logic                           busy,
  output logic                           ar_valid,
  output logic [ADDR_WDTH-1:0]           ar_addr,
  input  logic                           ar_ready,
  input  logic                           r_valid,
  input  logic [DATA_WDTH-1:0]           r_data,
  input  logic [RESP_WDTH-1:0]           r_resp,
  output logic                           r_ready,
  output logic                           aw_valid,
  output logic [ADDR_WDTH-1:0]           aw_addr,
  input  logic                           aw_ready,
  output logic                           w_valid,
  output logic [DATA_WDTH-1:0]           w_data,
  input  logic                           w_ready,
  input  logic                           b_valid,
  input  logic [RESP_WDTH-1:0]           b_resp,
  output logic                           b_ready
);

  localparam int IDX_WDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state_q, state_d;
  logic [IDX_WDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_WDTH-1:0]   gnt_q, gnt_d;
  logic [ADDR_WDTH-1:0]  addr_q, addr_d;
  logic [DATA_WDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WDTH-1:0]  rdata_q, rdata_d;
  logic [RESP_WDTH-1:0]  resp_q, resp_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_WDTH-1:0]   pick_idx;
  logic                  pick_any;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WDTH (IDX_WDTH)
  ) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    logic aw_hs;
    logic w_hs;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_oh;
          gnt_d     = pick_idx;
          rr_ptr_d  = pick_idx;
          addr_d    = req_addr[pick_idx*ADDR_WDTH +: ADDR_WDTH];
          wdata_d   = req_wdata[pick_idx*DATA_WDTH +: DATA_WDTH];
          state_d   = req_we[pick_idx] ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: if (ar_ready) state_d = RD_DATA;
      RD_DATA: begin
        if (r_valid) begin
          rdata_d = r_data;
          resp_d  = r_resp;
          state_d = RSP;
        end
      end
      WR_ADDR: begin
        // Address and data channels complete independently, in either order.
        aw_hs = !aw_done_q && aw_ready;
        w_hs  = !w_done_q && w_ready;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WR_RESP: begin
        if (b_valid) begin
          resp_d  = b_resp;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IDX_WDTH'(NUM_REQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_WDTH'(RESP_OKAY);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RSP) rsp_valid[gnt_q] = 1'b1;
  end

  assign busy      = (state_q != IDLE);
  assign ar_valid  = (state_q == RD_ADDR);
  assign ar_addr   = addr_q;
  assign r_ready   = (state_q == RD_DATA);
  assign aw_valid  = (state_q == WR_ADDR) && !aw_done_q;
  assign aw_addr   = addr_q;
  assign w_valid   = (state_q == WR_ADDR) && !w_done_q;
  assign w_data    = wdata_q;
  assign b_ready   = (state_q == WR_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: random requesters and a stalling memory, checked every cycle against a transaction-level model.
// Includes ar back-pressure bursts, error responses, stray r/b valids and a mid-read reset.
module tb_mem_port_arbiter;
  localparam int NR = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic [RW-1:0]    rsp_resp;
  logic             busy;
  logic             ar_valid, ar_ready, r_valid, r_ready;
  logic             aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [AW-1:0]    ar_addr, aw_addr;
  logic [DW-1:0]    r_data, w_data;
  logic [RW-1:0]    r_resp, b_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requesters: 0 idle, 1 requesting, 2 accepted and awaiting response
  int            rq_st[NR];
  logic          rq_we[NR];
  logic [AW-1:0] rq_addr[NR];
  logic [DW-1:0] rq_wd[NR];

  // Transaction-level reference model
  bit            m_act, m_wr, m_ar, m_r, m_aw, m_w, m_b;
  int            m_who, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;
  logic [RW-1:0] m_resp;
  logic [DW-1:0] ref_arr[16];

  // Memory device
  logic [DW-1:0] mem_arr[16];
  bit            d_rd, d_aw, d_w;
  logic [AW-1:0] d_ra, d_wa;
  logic [DW-1:0] d_wd;
  int            bp_left;

  int  done_cnt = 0;
  bit  did_rst = 0;
  bit  force_both = 0;
  bit  post_rst = 0;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int i = 1; i <= NR; i++) begin
      if (v[(last + i) % NR]) return (last + i) % NR;
    end
    return -1;
  endfunction

  task automatic reset_model();
    m_act = 0; m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; m_wr = 0;
    m_last = NR - 1; m_who = 0;
    d_rd = 0; d_aw = 0; d_w = 0; bp_left = 0;
    for (int k = 0; k < NR; k++) rq_st[k] = 0;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      if (rq_st[k] == 0 && (($urandom_range(0, 9) < 4) || (force_both && k < 2))) begin
        rq_st[k]   = 1;
        rq_we[k]   = force_both ? 1'b0 : 1'($urandom_range(0, 1));
        rq_addr[k] = AW'($urandom_range(0, 15));
        rq_wd[k]   = $urandom;
      end else if (rq_st[k] == 1 && $urandom_range(0, 19) == 0) begin
        rq_st[k] = 0;
      end
      req_valid[k]          = (rq_st[k] == 1);
      req_we[k]             = rq_we[k];
      req_addr[k*AW +: AW]  = rq_addr[k];
      req_wdata[k*DW +: DW] = rq_wd[k];
    end
    force_both = 0;
    ar_ready = (bp_left > 0) ? 1'b0 : ($urandom_range(0, 9) < 6);
    if (bp_left > 0) bp_left--;
    r_valid  = d_rd ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
    r_data   = d_rd ? mem_arr[d_ra] : $urandom;
    r_resp   = RW'($urandom_range(0, 4) == 0);
    aw_ready = ($urandom_range(0, 9) < 6);
    w_ready  = ($urandom_range(0, 9) < 6);
    b_valid  = (d_aw && d_w) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
    b_resp   = RW'($urandom_range(0, 4) == 0);
  endtask

  task automatic check_and_step();
    logic [NR-1:0] e_rdy, e_rsp;
    bit e_ar, e_r, e_aw, e_w, e_b, e_rspv;
    int g;
    g = -1;
    e_rdy = '0;
    e_rsp = '0;
    if (!m_act) begin
      g = rr_pick(req_valid, m_last);
      if (g >= 0) e_rdy[g] = 1'b1;
    end
    e_ar   = m_act && !m_wr && !m_ar;
    e_r    = m_act && !m_wr && m_ar && !m_r;
    e_aw   = m_act && m_wr && !m_aw;
    e_w    = m_act && m_wr && !m_w;
    e_b    = m_act && m_wr && m_aw && m_w && !m_b;
    e_rspv = m_act && (m_r || m_b);
    if (e_rspv) e_rsp[m_who] = 1'b1;

    check_val("req_ready", 64'(req_ready), 64'(e_rdy));
    if (post_rst) begin
      check_val("post_rst_gnt", 64'(req_ready), 64'(3'b001));
      post_rst = 0;
    end
    check_val("busy", 64'(busy), 64'(m_act));
    check_val("ar_valid", 64'(ar_valid), 64'(e_ar));
    if (e_ar) check_val("ar_addr", 64'(ar_addr), 64'(m_addr));
    check_val("r_ready", 64'(r_ready), 64'(e_r));
    check_val("aw_valid", 64'(aw_valid), 64'(e_aw));
    if (e_aw) check_val("aw_addr", 64'(aw_addr), 64'(m_addr));
    check_val("w_valid", 64'(w_valid), 64'(e_w));
    if (e_w) check_val("w_data", 64'(w_data), 64'(m_wd));
    check_val("b_ready", 64'(b_ready), 64'(e_b));
    check_val("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_rspv) begin
      check_val("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      check_val("rsp_resp", 64'(rsp_resp), 64'(m_resp));
    end

    // Memory device reacts to what the DUT actually presents.
    if (ar_valid && ar_ready) begin d_rd = 1; d_ra = ar_addr; end
    else if (r_ready && r_valid && d_rd) d_rd = 0;
    if (aw_valid && aw_ready) begin d_aw = 1; d_wa = aw_addr; end
    if (w_valid && w_ready) begin d_w = 1; d_wd = w_data; end
    if (b_ready && b_valid && d_aw && d_w) begin
      mem_arr[d_wa] = d_wd; d_aw = 0; d_w = 0;
    end

    if (m_act) begin
      if (e_rspv) begin
        m_act = 0; rq_st[m_who] = 0; done_cnt++;
      end else begin
        if (e_ar && ar_ready) m_ar = 1;
        if (e_r && r_valid) begin m_r = 1; m_resp = r_resp; end
        if (e_aw && aw_ready) m_aw = 1;
        if (e_w && w_ready) m_w = 1;
        if (e_b && b_valid) begin m_b = 1; m_resp = b_resp; end
      end
    end else if (g >= 0) begin
      m_act = 1; m_who = g; m_last = g; m_wr = rq_we[g];
      m_addr = rq_addr[g]; m_wd = rq_wd[g];
      m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0;
      rq_st[g] = 2;
      if (m_wr) begin
        ref_arr[m_addr] = m_wd;
        m_rdata = '0;
      end else begin
        m_rdata = ref_arr[m_addr];
        if ($urandom_range(0, 3) == 0) bp_left = 10;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom; ref_arr[i] = v; mem_arr[i] = v;
    end
    for (int k = 0; k < NR; k++) begin
      rq_we[k] = 0; rq_addr[k] = '0; rq_wd[k] = '0;
    end
    reset_model();
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    #2;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valids", 64'({ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'd0);
    check_val("rst_rsp", 64'({rsp_valid, req_ready}), 64'd0);
    check_val("rst_data", 64'({rsp_rdata, rsp_resp}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      drive_inputs();
      #1;
      if (cyc >= 1500 && !did_rst && m_act && !m_wr && m_ar && !m_r) begin
        did_rst = 1;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_valids", 64'({ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'd0);
        check_val("midrst_rsp", 64'({rsp_valid, req_ready}), 64'd0);
        check_val("midrst_data", 64'({rsp_rdata, rsp_resp, ar_addr, w_data}), 64'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        force_both = 1;
        post_rst = 1;
      end else begin
        check_and_step();
      end
    end

    check_val("txn_progress", 64'(done_cnt > 200), 64'd1);
    check_val("reset_exercised", 64'(did_rst), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one AXI-lite-style memory port (AR/R/AW/W/B channels) between NUM_REQ requesters, such as the sort controller's read path and the write submodule. Each requester uses a simple request/response handshake. The arbiter grants requests round-robin and runs exactly one memory transaction at a time, read or write. It returns read data and the response code to the granted requester only.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WDTH, 4, memory address width
DATA_WDTH, 32, memory data width
RESP_WDTH, 1, response code width; 0 = OKAY, nonzero = error

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request pending
req_we  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_WDTH  packed addresses; requester k occupies bits [k*ADDR_WDTH +: ADDR_WDTH]
req_wdata  input  NUM_REQ*DATA_WDTH  packed write data, same packing rule
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  output  DATA_WDTH  read data; valid only while a rsp_valid bit is high
rsp_resp  output  RESP_WDTH  response code; valid only while a rsp_valid bit is high
busy  output  1  high whenever state != IDLE
ar_valid, ar_addr  output  1, ADDR_WDTH  read address channel
ar_ready  input  1  read address channel ready
r_valid, r_data, r_resp  input  1, DATA_WDTH, RESP_WDTH  read data channel
r_ready  output  1  read data channel ready
aw_valid, aw_addr  output  1, ADDR_WDTH  write address channel
aw_ready  input  1  write address channel ready
w_valid, w_data  output  1, DATA_WDTH  write data channel
w_ready  input  1  write data channel ready
b_valid, b_resp  input  1, RESP_WDTH  write response channel
b_ready  output  1  write response channel ready

Behaviour:
- Reset: state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first; all valid/ready outputs 0; addr, data, rsp_rdata and rsp_resp 0; aw_done=w_done=0.
- Requester rule: req_valid, req_we, addr and wdata are held stable until req_ready is seen. Dropping req_valid before acceptance is allowed; the arbiter then simply does not grant that requester.
- IDLE: grant g = first set req_valid bit searching from rr_ptr+1 with wrap-around.
  - req_ready[g]=1 combinationally in that cycle.
  - Registers updated: gnt<=g, addr, wdata and we latched, rr_ptr<=g.
  - Next state is RD_ADDR if we=0, else WR_ADDR.
  - No req_valid: stay in IDLE.
- RD_ADDR: ar_valid=1, ar_addr=latched addr. On ar_ready, go to RD_DATA.
- RD_DATA: r_ready=1. On r_valid, capture r_data and r_resp, go to RSP.
- WR_ADDR: aw_valid=!aw_done, w_valid=!w_done.
  - Each channel's done flag sets on its own handshake. Either order, or both in the same cycle, is legal.
  - When both handshakes have completed (including completion in the current cycle), go to WR_RESP and clear both flags.
- WR_RESP: b_ready=1. On b_valid, capture b_resp, set rsp_rdata=0, go to RSP.
- RSP: rsp_valid[gnt]=1 for exactly one cycle, then IDLE.
- The arbiter never asserts req_ready in RSP. The earliest next grant is the cycle after RSP.
- Minimum latency (memory ready immediately), with the accept cycle as t0:
  - Read: ar at t1, r at t2, rsp_valid at t3.
  - Write: aw and w at t1, b at t2, rsp_valid at t3.
- An error response is passed through unchanged. The arbiter does not retry.
- Only one transaction is ever in flight. A new requester asserting req_valid mid-transaction waits.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0,…
- Stray r_valid or b_valid outside RD_DATA or WR_RESP is ignored (ready=0).
- Reset mid-operation: immediate return to reset values. The outstanding memory transaction is abandoned, and the memory is reset by the same rst_n.

Decomposition:
- Shared package (mem_if_pkg): state encoding constants (IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RSP), RESP_OKAY=0, STATE_WDTH=3.
- Sub-module rr_arbiter (purely combinational): inputs req vector and rr_ptr; outputs one-hot grant and its index. The FSM and all registers stay in mem_port_arbiter.

Test Plan:
1. Single read: req0 read at addr 0x3; memory returns ar_ready at once and r_data=0xDEADBEEF, r_resp=0 next cycle. Required: rsp_valid[0] three cycles after req_ready[0], rsp_rdata=0xDEADBEEF, rsp_valid[1]=0 throughout.
2. Write with skewed channels: req1 writes 0x12345678 to 0x5; w_ready comes 2 cycles before aw_ready. Required: w_valid drops after its handshake, aw_valid stays high until aw_ready, a single b handshake follows, then rsp_valid[1] with rsp_resp=0.
3. Contention: req0 and req1 both hold valid for 4 transactions. Required grant order 0,1,0,1, and each requester sees exactly one req_ready and one rsp_valid per transaction.
4. Error response: read returning r_resp=1. Required: rsp_resp=1 on rsp_valid; the arbiter returns to IDLE and the next request is served normally.
5. Back-pressure: ar_ready held 0 for 10 cycles. Required: ar_valid and ar_addr stay stable for all 10 cycles, and busy=1.
6. Reset mid-transaction: rst_n asserted while in RD_DATA. Required: all outputs 0 immediately; after release, requester 0 is granted first when both request.
